pwm_bank_ctrl: RTL and testbench

//  Parametrised N-channel PWM peripheral; successor to the single fixed 8-bit PWM fed by the GPIO register.

---
 rtl/pwm_bank_pkg.sv | 29 ++
 rtl/pwm_bank_ctrl_channel.sv | 47 ++++
 rtl/pwm_bank_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pwm_bank_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Register map, bit positions and enums shared by the PWM bank.
package pwm_bank_pkg;

  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_PERIOD   = 1;
  localparam int unsigned ADDR_PRESCALE = 2;
  localparam int unsigned ADDR_STATUS   = 3;
  localparam int unsigned DUTY_BASE     = 4;

  localparam int unsigned CTRL_W        = 4;
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_INV      = 1;
  localparam int unsigned CTRL_CENTRE   = 2;
  localparam int unsigned CTRL_IRQ_EN   = 3;

  localparam int unsigned STAT_UPD      = 0;
  localparam int unsigned STAT_PFLAG    = 1;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_bank_ctrl_channel.sv
// One PWM channel: double-buffered duty, comparator against the shared counter, output flop.
module pwm_channel #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          inv,
  input  logic          centre,
  input  logic          wr,
  input  logic          load,
  input  logic [CW-1:0] wdata,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] top,
  output logic [CW-1:0] duty,
  output logic          pwm
);

  logic [CW-1:0] duty_act;
  logic          raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty     <= '0;
      duty_act <= '0;
    end else begin
      if (wr)   duty     <= wdata;
      if (load) duty_act <= duty;
    end
  end

  // Saturating duties are forced so the output never glitches at the counter turn-around.
  always_comb begin
    raw = 1'b0;
    if (duty_act == '0)                                raw = 1'b0;
    else if (!centre && (duty_act > top))              raw = 1'b1;
    else if (centre && (top != '0) && (duty_act >= top)) raw = 1'b1;
    else                                               raw = (cnt < duty_act);
  end

  always_ff @(posedge clk) begin
    if (rst)     pwm <= 1'b0;
    else if (en) pwm <= raw ^ inv;
    else         pwm <= inv;
  end

endmodule

// File: rtl/pwm_bank_ctrl.sv
// N-channel PWM peripheral: register file, prescaler, shared up/up-down counter and period IRQ.
module pwm_bank_ctrl
  import pwm_bank_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8,
  parameter int unsigned AW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic           rd_en,
  input  logic [AW-1:0]  addr,
  input  logic [CW-1:0]  wdata,
  output logic [CW-1:0]  rdata,
  output logic [NCH-1:0] pwm_out,
  output logic           period_stb,
  output logic           irq
);

  logic [CTRL_W-1:0] ctrl, ctrl_nxt;
  logic [CW-1:0]     period_sh, top, prescale, pcnt, cnt;
  logic [CW-1:0]     pcnt_nxt, cnt_nxt, rd_val;
  logic              upd_pend, pflag, upd_nxt, pflag_nxt;
  logic              en, tick, bnd, load;
  logic              wr_ctrl, wr_period, wr_pre, wr_status;
  logic [NCH-1:0]    duty_wr;
  logic [CW-1:0]     duty_sh [NCH];
  mode_e             mode;
  dir_e              dir, dir_nxt;

  assign wr_ctrl   = wr_en && (addr == AW'(ADDR_CTRL));
  assign wr_period = wr_en && (addr == AW'(ADDR_PERIOD));
  assign wr_pre    = wr_en && (addr == AW'(ADDR_PRESCALE));
  assign wr_status = wr_en && (addr == AW'(ADDR_STATUS));
  assign en        = ctrl[CTRL_EN];
  assign mode      = mode_e'(ctrl[CTRL_CENTRE]);
  // While disabled the shadows flow straight through to the active copies.
  assign load      = bnd || !en;

  always_ff @(posedge clk) begin
    if (rst) dir <= DIR_UP;
    else     dir <= dir_nxt;
  end

  // Prescaler, counter and direction; bnd marks the tick that closes a period.
  always_comb begin
    dir_nxt  = dir;
    cnt_nxt  = cnt;
    pcnt_nxt = pcnt;
    tick     = 1'b0;
    bnd      = 1'b0;
    if (!en) begin
      dir_nxt  = DIR_UP;
      cnt_nxt  = '0;
      pcnt_nxt = '0;
    end else begin
      tick     = (pcnt >= prescale);
      pcnt_nxt = tick ? '0 : pcnt + CW'(1);
      if (tick) begin
        if (top == '0) begin
          bnd     = 1'b1;
          cnt_nxt = '0;
          dir_nxt = DIR_UP;
        end else if (mode == MODE_EDGE) begin
          dir_nxt = DIR_UP;
          if (cnt >= top) begin
            bnd     = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          case (dir)
            DIR_UP: begin
              if (cnt >= top) begin
                dir_nxt = DIR_DOWN;
                cnt_nxt = cnt - CW'(1);
              end else begin
                cnt_nxt = cnt + CW'(1);
              end
            end
            DIR_DOWN: begin
              if (cnt == '0) begin
                bnd     = 1'b1;
                dir_nxt = DIR_UP;
                cnt_nxt = (period_sh == '0) ? '0 : CW'(1);
              end else begin
                cnt_nxt = cnt - CW'(1);
              end
            end
          endcase
        end
      end
    end
  end

  // Update-pending and period flag: a set in the same cycle beats a clear.
  always_comb begin
    ctrl_nxt  = wr_ctrl ? wdata[CTRL_W-1:0] : ctrl;
    upd_nxt   = upd_pend;
    pflag_nxt = pflag;
    if (load) upd_nxt = 1'b0;
    if (wr_period || (|duty_wr)) upd_nxt = 1'b1;
    if (wr_status && wdata[STAT_PFLAG]) pflag_nxt = 1'b0;
    if (bnd) pflag_nxt = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      AW'(ADDR_CTRL):     rd_val = CW'(ctrl);
      AW'(ADDR_PERIOD):   rd_val = period_sh;
      AW'(ADDR_PRESCALE): rd_val = prescale;
      AW'(ADDR_STATUS):   rd_val = CW'({pflag, upd_pend});
      default:            rd_val = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (addr == AW'(DUTY_BASE + i)) rd_val = duty_sh[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      period_sh  <= '1;
      top        <= '1;
      prescale   <= '0;
      pcnt       <= '0;
      cnt        <= '0;
      upd_pend   <= 1'b0;
      pflag      <= 1'b0;
      rdata      <= '0;
      period_stb <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ctrl       <= ctrl_nxt;
      if (wr_period) period_sh <= wdata;
      if (wr_pre)    prescale  <= wdata;
      if (load)      top       <= period_sh;
      pcnt       <= pcnt_nxt;
      cnt        <= cnt_nxt;
      upd_pend   <= upd_nxt;
      pflag      <= pflag_nxt;
      period_stb <= bnd;
      irq        <= pflag_nxt & ctrl_nxt[CTRL_IRQ_EN];
      if (rd_en) rdata <= rd_val;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign duty_wr[g] = wr_en && (addr == AW'(DUTY_BASE + g));

    pwm_channel #(.CW(CW)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .inv    (ctrl[CTRL_INV]),
      .centre (ctrl[CTRL_CENTRE]),
      .wr     (duty_wr[g]),
      .load   (load),
      .wdata  (wdata),
      .cnt    (cnt),
      .top    (top),
      .duty   (duty_sh[g]),
      .pwm    (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Bench for pwm_bank_ctrl: directed scenarios then random register traffic, checked every cycle
// against a model that tracks the position inside the PWM period rather than a counter FSM.
module tb_pwm_bank_ctrl;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned AW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic           rd_en;
  logic [AW-1:0]  addr;
  logic [CW-1:0]  wdata;
  logic [CW-1:0]  rdata;
  logic [NCH-1:0] pwm_out;
  logic           period_stb;
  logic           irq;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit [3:0]     m_ctrl;
  int           m_psh, m_top, m_pre, m_pcnt, m_pos;
  int           m_dsh [NCH];
  int           m_dact[NCH];
  bit           m_upd, m_pflag;
  bit [NCH-1:0] e_pwm;
  bit           e_stb, e_irq;
  int           e_rdata;

  pwm_bank_ctrl #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .pwm_out    (pwm_out),
    .period_stb (period_stb),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit ref_raw(input int d, input int c, input int t, input bit ctr);
    if (d == 0) return 1'b0;
    if (!ctr && d > t) return 1'b1;
    if (ctr && t != 0 && d >= t) return 1'b1;
    return (c < d);
  endfunction

  // True when the coming clock edge closes a period.
  function automatic bit ref_bnd();
    if (!m_ctrl[0] || m_pcnt != m_pre) return 1'b0;
    if (m_top == 0) return 1'b1;
    return m_ctrl[2] ? (m_pos == 2 * m_top) : (m_pos == m_top);
  endfunction

  function automatic int ref_read(input int a);
    if (a == 0) return int'(m_ctrl);
    if (a == 1) return m_psh;
    if (a == 2) return m_pre;
    if (a == 3) return 2 * int'(m_pflag) + int'(m_upd);
    if (a >= 4 && a < 4 + int'(NCH)) return m_dsh[a-4];
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit w, input bit rd, input int a, input int d);
    bit en, inv, ctr, bnd;
    int cnt, rv;
    if (r) begin
      m_ctrl = '0; m_psh = 255; m_top = 255; m_pre = 0; m_pcnt = 0; m_pos = 0;
      m_upd = 0; m_pflag = 0;
      for (int i = 0; i < NCH; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
      e_pwm = '0; e_stb = 0; e_irq = 0; e_rdata = 0;
    end else begin
      en  = m_ctrl[0];
      inv = m_ctrl[1];
      ctr = m_ctrl[2];
      // Centre mode folds the period position back down after the peak.
      cnt = (ctr && m_pos > m_top) ? 2 * m_top - m_pos : m_pos;
      for (int i = 0; i < NCH; i++)
        e_pwm[i] = en ? (ref_raw(m_dact[i], cnt, m_top, ctr) ^ inv) : inv;
      rv  = ref_read(a);
      bnd = ref_bnd();
      if (!en) begin
        m_pos = 0; m_pcnt = 0;
      end else if (m_pcnt == m_pre) begin
        m_pcnt = 0;
        if (bnd) m_pos = (ctr && m_top != 0 && m_psh != 0) ? 1 : 0;
        else     m_pos++;
      end else begin
        m_pcnt++;
      end
      if (bnd || !en) begin
        m_top = m_psh;
        for (int i = 0; i < NCH; i++) m_dact[i] = m_dsh[i];
        m_upd = 0;
      end
      if (w) begin
        if (a == 0) m_ctrl = 4'(d);
        else if (a == 1) begin m_psh = d; m_upd = 1; end
        else if (a == 2) m_pre = d;
        else if (a == 3) begin if ((d & 2) != 0) m_pflag = 0; end
        else if (a >= 4 && a < 4 + int'(NCH)) begin m_dsh[a-4] = d; m_upd = 1; end
      end
      if (bnd) m_pflag = 1;
      e_stb = bnd;
      e_irq = m_pflag & m_ctrl[3];
      if (rd) e_rdata = rv;
    end
  endtask

  task automatic cyc(input bit w, input bit rd, input int a, input int d);
    wr_en = w; rd_en = rd; addr = AW'(a); wdata = CW'(d);
    model_step(rst, w, rd, a, d);
    @(posedge clk); #1;
    check("pwm_out", 32'(pwm_out), 32'(e_pwm));
    check("period_stb", 32'(period_stb), 32'(e_stb));
    check("irq", 32'(irq), 32'(e_irq));
    check("rdata", 32'(rdata), 32'(e_rdata));
    wr_en = 0; rd_en = 0;
  endtask

  initial begin
    int hi, hi2, hi3, st, n;
    rst = 1; wr_en = 0; rd_en = 0; addr = '0; wdata = '0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 0;
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rdata", 32'(rdata), 0);
    cyc(0, 1, 1, 0);
    check("rst_period", 32'(rdata), 32'hFF);

    // Edge-aligned, TOP=9, duty 3
    cyc(1, 0, 1, 9); cyc(1, 0, 2, 0); cyc(1, 0, 4, 3); cyc(1, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0);
    hi = 0; st = 0;
    repeat (30) begin cyc(0, 0, 0, 0); hi += int'(pwm_out[0]); st += int'(period_stb); end
    check("edge_high", 32'(hi), 9);
    check("edge_stb", 32'(st), 3);

    // Double buffer: duty 3 -> 7 mid-period
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 0, 4, 7);
    cyc(0, 1, 3, 0);
    check("dbuf_pend", 32'(rdata[0]), 1);
    repeat (12) cyc(0, 0, 0, 0);
    cyc(0, 1, 3, 0);
    check("dbuf_clear", 32'(rdata[0]), 0);
    hi = 0;
    repeat (20) begin cyc(0, 0, 0, 0); hi += int'(pwm_out[0]); end
    check("dbuf_duty", 32'(hi), 14);

    // IRQ and W1C racing a boundary
    cyc(1, 0, 0, 9);
    n = 0;
    while (!ref_bnd() && n < 20) begin cyc(0, 0, 0, 0); n++; end
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 0, 3, 2);
    check("irq_cleared", 32'(irq), 0);
    n = 0;
    while (!ref_bnd() && n < 20) begin cyc(0, 0, 0, 0); n++; end
    check("irq_sync", 32'(n < 20), 1);
    cyc(1, 0, 3, 2);
    check("irq_set_wins", 32'(irq), 1);
    cyc(0, 1, 3, 0);
    check("pflag_kept", 32'(rdata[1]), 1);
    cyc(1, 0, 3, 2);
    cyc(0, 1, 3, 0);
    check("pflag_w1c", 32'(rdata[1]), 0);
    check("irq_w1c", 32'(irq), 0);

    // Extremes: duty 0, duty beyond TOP, then TOP=0
    cyc(1, 0, 0, 0); cyc(1, 0, 6, 0); cyc(1, 0, 7, 10); cyc(1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);
    hi2 = 0; hi3 = 0;
    repeat (20) begin cyc(0, 0, 0, 0); hi2 += int'(pwm_out[2]); hi3 += int'(pwm_out[3]); end
    check("duty_zero", 32'(hi2), 0);
    check("duty_full", 32'(hi3), 20);
    cyc(1, 0, 1, 0);
    repeat (12) cyc(0, 0, 0, 0);
    st = 0;
    repeat (10) begin cyc(0, 0, 0, 0); st += int'(period_stb); end
    check("top0_stb", 32'(st), 10);

    // Centre-aligned with inversion, TOP=4
    cyc(1, 0, 0, 0); cyc(1, 0, 1, 4); cyc(1, 0, 5, 2); cyc(1, 0, 0, 7);
    repeat (4) cyc(0, 0, 0, 0);
    st = 0;
    repeat (16) begin cyc(0, 0, 0, 0); st += int'(period_stb); end
    check("centre_stb", 32'(st), 2);

    // Randomized configurations and register traffic
    for (int r = 0; r < 30; r++) begin
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, int'($urandom_range(0, 15)));
      cyc(1, 0, 2, int'($urandom_range(0, 3)));
      for (int i = 0; i < NCH; i++) cyc(1, 0, 4 + i, int'($urandom_range(0, 17)));
      cyc(1, 0, 0, 1 + 2 * int'($urandom_range(0, 7)));
      for (int k = 0; k < 60; k++) begin
        int op, a;
        op = int'($urandom_range(0, 9));
        a  = int'($urandom_range(1, 15));
        if (a == 2) a = 3;
        if (op == 0)      cyc(1, 0, a, int'($urandom_range(0, 17)));
        else if (op == 1) cyc(0, 1, int'($urandom_range(0, 15)), 0);
        else if (op == 2) cyc(1, 1, a, int'($urandom_range(0, 17)));
        else              cyc(0, 0, 0, 0);
      end
    end

    // Reset while running
    rst = 1;
    cyc(0, 0, 0, 0);
    rst = 0;
    check("midrst_pwm", 32'(pwm_out), 0);
    check("midrst_stb", 32'(period_stb), 0);
    repeat (4) cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
